// File: rtl/rs_pkg.sv
// rs_pkg -- shared types and constants for the integer reservation station.
//   OPCODE_W          : opcode width carried through the station
//   RS_XLEN / RS_TAGW : default operand and ROB-tag widths
//   RS_DEPTH          : default number of station entries
//   rs_entry_t        : one station slot (operands, readiness, producer tags)
//   operand_hit()     : CDB wakeup compare for a single operand
package rs_pkg;

  localparam int OPCODE_W = 7;
  localparam int RS_XLEN  = 64;
  localparam int RS_TAGW  = 6;
  localparam int RS_DEPTH = 4;

  typedef struct packed {
    logic                valid;
    logic [OPCODE_W-1:0] opcode;
    logic [RS_XLEN-1:0]  a_val;
    logic                a_rdy;
    logic [RS_TAGW-1:0]  a_tag;
    logic [RS_XLEN-1:0]  b_val;
    logic                b_rdy;
    logic [RS_TAGW-1:0]  b_tag;
    logic [RS_TAGW-1:0]  rd;
    logic [RS_TAGW-1:0]  tag;
  } rs_entry_t;

  localparam rs_entry_t RS_ENTRY_EMPTY = '0;

  // An operand wakes only while it is still waiting; a tag match on an
  // already-ready operand must not overwrite its value.
  function automatic logic operand_hit(
    input logic               entry_valid,
    input logic               rdy,
    input logic [RS_TAGW-1:0] tag,
    input logic               cdb_valid,
    input logic [RS_TAGW-1:0] cdb_tag
  );
    return entry_valid && !rdy && cdb_valid && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_int_scheduler_if.sv
// rs_int_scheduler_if -- dispatch, CDB, issue and status signals of the
// integer reservation station, bundled for port connection.
//   slave  : the station side (rs_int_scheduler)
//   master : the environment side (dispatch, CDB source, integer unit)
// Signal names follow the surrounding pipeline's naming.
interface rs_int_scheduler_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int TAGW  = 6
) ();

  // control
  logic                         flush;
  // dispatch -> station
  logic                         valid_disp2rs;
  logic [6:0]                   opcode_disp2rs;
  logic [XLEN-1:0]              a_val_disp2rs;
  logic [XLEN-1:0]              b_val_disp2rs;
  logic                         a_rdy_disp2rs;
  logic                         b_rdy_disp2rs;
  logic [TAGW-1:0]              a_tag_disp2rs;
  logic [TAGW-1:0]              b_tag_disp2rs;
  logic [TAGW-1:0]              rd_disp2rs;
  logic [TAGW-1:0]              tag_disp2rs;
  logic                         full_rs2disp;
  // result broadcast
  logic                         cdb_valid;
  logic [TAGW-1:0]              cdb_tag;
  logic [XLEN-1:0]              cdb_result;
  // station -> integer unit
  logic                         valid_rs2int;
  logic [6:0]                   opcode_rs2int;
  logic [XLEN-1:0]              a_rs2int;
  logic [XLEN-1:0]              b_rs2int;
  logic [TAGW-1:0]              rd_rs2int;
  logic [TAGW-1:0]              tag_rs2int;
  logic                         stop_int2rsint;
  // occupancy
  logic [$clog2(DEPTH+1)-1:0]   count_rs;

  modport slave (
    input  flush,
    input  valid_disp2rs, opcode_disp2rs, a_val_disp2rs, b_val_disp2rs,
    input  a_rdy_disp2rs, b_rdy_disp2rs, a_tag_disp2rs, b_tag_disp2rs,
    input  rd_disp2rs, tag_disp2rs,
    output full_rs2disp,
    input  cdb_valid, cdb_tag, cdb_result,
    output valid_rs2int, opcode_rs2int, a_rs2int, b_rs2int, rd_rs2int, tag_rs2int,
    input  stop_int2rsint,
    output count_rs
  );

  modport master (
    output flush,
    output valid_disp2rs, opcode_disp2rs, a_val_disp2rs, b_val_disp2rs,
    output a_rdy_disp2rs, b_rdy_disp2rs, a_tag_disp2rs, b_tag_disp2rs,
    output rd_disp2rs, tag_disp2rs,
    input  full_rs2disp,
    output cdb_valid, cdb_tag, cdb_result,
    input  valid_rs2int, opcode_rs2int, a_rs2int, b_rs2int, rd_rs2int, tag_rs2int,
    output stop_int2rsint,
    input  count_rs
  );

endinterface

// File: rtl/rs_entry_wakeup.sv
// rs_entry_wakeup -- combinational CDB snoop for one station entry.
//   entry_i      : entry as currently held (or as being dispatched)
//   cdb_valid_i  : result broadcast valid
//   cdb_tag_i    : broadcast producer tag
//   cdb_result_i : broadcast value
//   entry_o      : entry with any matching waiting operand captured and ready
// Both operands may wake from the same broadcast.
module rs_entry_wakeup
  import rs_pkg::*;
(
  input  rs_entry_t          entry_i,
  input  logic               cdb_valid_i,
  input  logic [RS_TAGW-1:0] cdb_tag_i,
  input  logic [RS_XLEN-1:0] cdb_result_i,
  output rs_entry_t          entry_o
);

  logic a_hit;
  logic b_hit;

  // Compare each waiting operand against the broadcast and capture on a hit.
  always_comb begin
    a_hit   = operand_hit(entry_i.valid, entry_i.a_rdy, entry_i.a_tag, cdb_valid_i, cdb_tag_i);
    b_hit   = operand_hit(entry_i.valid, entry_i.b_rdy, entry_i.b_tag, cdb_valid_i, cdb_tag_i);
    entry_o = entry_i;
    if (a_hit) begin
      entry_o.a_val = cdb_result_i;
      entry_o.a_rdy = 1'b1;
    end else begin
      entry_o.a_val = entry_i.a_val;
    end
    if (b_hit) begin
      entry_o.b_val = cdb_result_i;
      entry_o.b_rdy = 1'b1;
    end else begin
      entry_o.b_val = entry_i.b_val;
    end
  end

endmodule

// File: rtl/rs_int_scheduler.sv
// rs_int_scheduler -- integer reservation station and issue scheduler.
//   clk : clock
//   res : synchronous active-high reset
//   bus : rs_int_scheduler_if.slave
//         flush, dispatch request/fields, full_rs2disp,
//         CDB (cdb_valid/cdb_tag/cdb_result),
//         issue outputs (*_rs2int), stop_int2rsint, count_rs
// Storage is a collapsing queue: entry 0 is the oldest and valid entries
// always occupy indices 0..count-1. Each cycle the lowest-index entry with
// both operands ready (from registered state) is issued unless the integer
// unit asserts stop; entries above it shift down one slot.
// The entry storage is sized by rs_pkg; XLEN/TAGW must equal RS_XLEN/RS_TAGW.
module rs_int_scheduler
  import rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int XLEN  = RS_XLEN,
  parameter int TAGW  = RS_TAGW
) (
  input logic               clk,
  input logic               res,
  rs_int_scheduler_if.slave bus
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int IDXW = $clog2(DEPTH);

  rs_entry_t             entries_q [DEPTH];
  rs_entry_t             entries_d [DEPTH];
  // woken[0..DEPTH-1] are the held entries, woken[DEPTH] the dispatch bypass
  rs_entry_t             woken     [DEPTH+1];
  rs_entry_t             disp_entry;
  rs_entry_t             sel_entry;

  logic [CNTW-1:0]       count_q;
  logic [CNTW-1:0]       count_d;
  logic [CNTW-1:0]       wr_idx;
  logic [IDXW-1:0]       sel_idx;
  logic                  sel_found;
  logic                  issue;
  logic                  disp_acc;
  logic                  full;

  logic                  valid_q;
  logic [OPCODE_W-1:0]   opcode_q;
  logic [XLEN-1:0]       a_q;
  logic [XLEN-1:0]       b_q;
  logic [TAGW-1:0]       rd_q;
  logic [TAGW-1:0]       tag_q;

  // Full is judged on registered occupancy only, so an issue in this cycle
  // never makes room for this cycle's dispatch.
  assign full     = (count_q == CNTW'(DEPTH));
  assign disp_acc = bus.valid_disp2rs && !full && !bus.flush;
  assign issue    = sel_found && !bus.stop_int2rsint;

  // Build the dispatched entry from the dispatch bus.
  always_comb begin
    disp_entry        = RS_ENTRY_EMPTY;
    disp_entry.valid  = 1'b1;
    disp_entry.opcode = bus.opcode_disp2rs;
    disp_entry.a_val  = bus.a_val_disp2rs;
    disp_entry.a_rdy  = bus.a_rdy_disp2rs;
    disp_entry.a_tag  = bus.a_tag_disp2rs;
    disp_entry.b_val  = bus.b_val_disp2rs;
    disp_entry.b_rdy  = bus.b_rdy_disp2rs;
    disp_entry.b_tag  = bus.b_tag_disp2rs;
    disp_entry.rd     = bus.rd_disp2rs;
    disp_entry.tag    = bus.tag_disp2rs;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    rs_entry_wakeup u_wake (
      .entry_i      (entries_q[g]),
      .cdb_valid_i  (bus.cdb_valid),
      .cdb_tag_i    (bus.cdb_tag),
      .cdb_result_i (bus.cdb_result),
      .entry_o      (woken[g])
    );
  end

  rs_entry_wakeup u_wake_disp (
    .entry_i      (disp_entry),
    .cdb_valid_i  (bus.cdb_valid),
    .cdb_tag_i    (bus.cdb_tag),
    .cdb_result_i (bus.cdb_result),
    .entry_o      (woken[DEPTH])
  );

  // Select the oldest fully-ready entry; scanning from the top down lets the
  // lowest index win.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_entry = RS_ENTRY_EMPTY;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries_q[i].valid && entries_q[i].a_rdy && entries_q[i].b_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
        sel_entry = entries_q[i];
      end else begin
        sel_found = sel_found;
      end
    end
  end

  // Next queue contents: collapse over the issued slot, then append dispatch.
  always_comb begin
    // When an entry leaves this edge the append slot moves down by one.
    wr_idx  = count_q - CNTW'(issue);
    count_d = count_q + CNTW'(disp_acc) - CNTW'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && (i >= int'(sel_idx))) begin
        if (i < DEPTH - 1) begin
          entries_d[i] = woken[i+1];
        end else begin
          entries_d[i] = RS_ENTRY_EMPTY;
        end
      end else begin
        entries_d[i] = woken[i];
      end
      if (disp_acc && (CNTW'(i) == wr_idx)) begin
        entries_d[i] = woken[DEPTH];
      end else begin
        entries_d[i] = entries_d[i];
      end
    end
  end

  // State and issue-register update; flush drops all work but keeps the
  // last issued payload fields.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= RS_ENTRY_EMPTY;
      end
      count_q  <= '0;
      valid_q  <= 1'b0;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      tag_q    <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= RS_ENTRY_EMPTY;
      end
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
      valid_q <= issue;
      if (issue) begin
        opcode_q <= sel_entry.opcode;
        a_q      <= sel_entry.a_val;
        b_q      <= sel_entry.b_val;
        rd_q     <= sel_entry.rd;
        tag_q    <= sel_entry.tag;
      end
    end
  end

  assign bus.full_rs2disp  = full;
  assign bus.count_rs      = count_q;
  assign bus.valid_rs2int  = valid_q;
  assign bus.opcode_rs2int = opcode_q;
  assign bus.a_rs2int      = a_q;
  assign bus.b_rs2int      = b_q;
  assign bus.rd_rs2int     = rd_q;
  assign bus.tag_rs2int    = tag_q;

endmodule

// File: tb/tb_rs_int_scheduler.sv
// tb_rs_int_scheduler -- directed self-checking bench for rs_int_scheduler.
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point, i.e. they show the state registered at the preceding edge.
module tb_rs_int_scheduler;

  logic clk;
  logic res;
  int   tests_run;
  int   tests_failed;

  rs_int_scheduler_if #(.DEPTH(4), .XLEN(64), .TAGW(6)) bus ();

  rs_int_scheduler #(.DEPTH(4), .XLEN(64), .TAGW(6)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_disp2rs  = 1'b0;
    bus.opcode_disp2rs = 7'd0;
    bus.a_val_disp2rs  = 64'd0;
    bus.b_val_disp2rs  = 64'd0;
    bus.a_rdy_disp2rs  = 1'b0;
    bus.b_rdy_disp2rs  = 1'b0;
    bus.a_tag_disp2rs  = 6'd0;
    bus.b_tag_disp2rs  = 6'd0;
    bus.rd_disp2rs     = 6'd0;
    bus.tag_disp2rs    = 6'd0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_tag        = 6'd0;
    bus.cdb_result     = 64'd0;
    bus.flush          = 1'b0;
  endtask

  task automatic drive_disp(input logic [6:0] opc,
                            input logic [63:0] av, input logic ar, input logic [5:0] at,
                            input logic [63:0] bv, input logic br, input logic [5:0] bt,
                            input logic [5:0] rd, input logic [5:0] tg);
    bus.valid_disp2rs  = 1'b1;
    bus.opcode_disp2rs = opc;
    bus.a_val_disp2rs  = av;
    bus.a_rdy_disp2rs  = ar;
    bus.a_tag_disp2rs  = at;
    bus.b_val_disp2rs  = bv;
    bus.b_rdy_disp2rs  = br;
    bus.b_tag_disp2rs  = bt;
    bus.rd_disp2rs     = rd;
    bus.tag_disp2rs    = tg;
  endtask

  task automatic check_idle(input string name);
    check_eq({name, "_valid"}, 64'(bus.valid_rs2int), 64'd0);
    check_eq({name, "_count"}, 64'(bus.count_rs), 64'd0);
    check_eq({name, "_full"},  64'(bus.full_rs2disp), 64'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    res = 1'b1;
    bus.stop_int2rsint = 1'b0;
    idle_inputs();

    // Reset then idle
    step();
    step();
    check_idle("reset");
    check_eq("reset_a",   bus.a_rs2int, 64'd0);
    check_eq("reset_b",   bus.b_rs2int, 64'd0);
    check_eq("reset_tag", 64'(bus.tag_rs2int), 64'd0);
    check_eq("reset_rd",  64'(bus.rd_rs2int), 64'd0);
    check_eq("reset_opc", 64'(bus.opcode_rs2int), 64'd0);
    res = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("idle");
    end

    // Ready dispatch: issued two cycles after dispatch
    drive_disp(7'h11, 64'd10, 1'b1, 6'd0, 64'd20, 1'b1, 6'd0, 6'd5, 6'd3);
    step();
    idle_inputs();
    check_eq("rdy_count1", 64'(bus.count_rs), 64'd1);
    check_eq("rdy_valid_early", 64'(bus.valid_rs2int), 64'd0);
    step();
    check_eq("rdy_valid", 64'(bus.valid_rs2int), 64'd1);
    check_eq("rdy_a",     bus.a_rs2int, 64'd10);
    check_eq("rdy_b",     bus.b_rs2int, 64'd20);
    check_eq("rdy_tag",   64'(bus.tag_rs2int), 64'd3);
    check_eq("rdy_rd",    64'(bus.rd_rs2int), 64'd5);
    check_eq("rdy_opc",   64'(bus.opcode_rs2int), 64'h11);
    step();
    check_eq("rdy_valid_after", 64'(bus.valid_rs2int), 64'd0);
    check_eq("rdy_count_after", 64'(bus.count_rs), 64'd0);

    // Wakeup, out of order
    drive_disp(7'h01, 64'd0, 1'b0, 6'd7, 64'd2, 1'b1, 6'd0, 6'd11, 6'd1);
    step();
    drive_disp(7'h02, 64'd3, 1'b1, 6'd0, 64'd4, 1'b1, 6'd0, 6'd12, 6'd2);
    step();
    idle_inputs();
    check_eq("wk_count2", 64'(bus.count_rs), 64'd2);
    bus.cdb_valid  = 1'b1;
    bus.cdb_tag    = 6'd7;
    bus.cdb_result = 64'h55;
    step();
    idle_inputs();
    check_eq("wk_first_valid", 64'(bus.valid_rs2int), 64'd1);
    check_eq("wk_first_tag",   64'(bus.tag_rs2int), 64'd2);
    check_eq("wk_first_a",     bus.a_rs2int, 64'd3);
    check_eq("wk_first_b",     bus.b_rs2int, 64'd4);
    check_eq("wk_count1",      64'(bus.count_rs), 64'd1);
    step();
    check_eq("wk_second_valid", 64'(bus.valid_rs2int), 64'd1);
    check_eq("wk_second_tag",   64'(bus.tag_rs2int), 64'd1);
    check_eq("wk_second_a",     bus.a_rs2int, 64'h55);
    check_eq("wk_second_b",     bus.b_rs2int, 64'd2);
    check_eq("wk_second_rd",    64'(bus.rd_rs2int), 64'd11);
    step();
    check_idle("wk_drain");

    // Dispatch bypass; a ready operand with a matching tag keeps its value
    drive_disp(7'h04, 64'd1, 1'b1, 6'd9, 64'd0, 1'b0, 6'd9, 6'd2, 6'd4);
    bus.cdb_valid  = 1'b1;
    bus.cdb_tag    = 6'd9;
    bus.cdb_result = 64'hAA;
    step();
    idle_inputs();
    step();
    check_eq("byp_valid", 64'(bus.valid_rs2int), 64'd1);
    check_eq("byp_tag",   64'(bus.tag_rs2int), 64'd4);
    check_eq("byp_b",     bus.b_rs2int, 64'hAA);
    check_eq("byp_a",     bus.a_rs2int, 64'd1);
    step();
    check_idle("byp_drain");

    // Full and stop
    bus.stop_int2rsint = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_disp(7'h20, 64'(i + 1), 1'b1, 6'd0, 64'(i + 101), 1'b1, 6'd0, 6'(i), 6'(10 + i));
      step();
    end
    check_eq("full_count", 64'(bus.count_rs), 64'd4);
    check_eq("full_flag",  64'(bus.full_rs2disp), 64'd1);
    check_eq("full_valid", 64'(bus.valid_rs2int), 64'd0);
    drive_disp(7'h20, 64'd99, 1'b1, 6'd0, 64'd99, 1'b1, 6'd0, 6'd9, 6'd14);
    step();
    idle_inputs();
    check_eq("drop_count", 64'(bus.count_rs), 64'd4);
    check_eq("drop_full",  64'(bus.full_rs2disp), 64'd1);
    check_eq("stop_valid", 64'(bus.valid_rs2int), 64'd0);
    bus.stop_int2rsint = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("drain_valid", 64'(bus.valid_rs2int), 64'd1);
      check_eq("drain_tag",   64'(bus.tag_rs2int), 64'(10 + i));
      check_eq("drain_a",     bus.a_rs2int, 64'(i + 1));
      check_eq("drain_b",     bus.b_rs2int, 64'(i + 101));
      check_eq("drain_count", 64'(bus.count_rs), 64'(3 - i));
      check_eq("drain_full",  64'(bus.full_rs2disp), 64'd0);
    end
    step();
    check_idle("drain_end");

    // Flush with pending issue and same-cycle dispatch
    bus.stop_int2rsint = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_disp(7'h30, 64'(i), 1'b1, 6'd0, 64'(i), 1'b1, 6'd0, 6'd1, 6'(20 + i));
      step();
    end
    check_eq("fl_count3", 64'(bus.count_rs), 64'd3);
    bus.stop_int2rsint = 1'b0;
    drive_disp(7'h30, 64'd7, 1'b1, 6'd0, 64'd7, 1'b1, 6'd0, 6'd1, 6'd23);
    bus.flush = 1'b1;
    step();
    idle_inputs();
    check_idle("flush");
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("post_flush");
    end

    // Dispatch and issue in the same cycle keep the count
    drive_disp(7'h40, 64'd30, 1'b1, 6'd0, 64'd31, 1'b1, 6'd0, 6'd3, 6'd30);
    step();
    check_eq("same_count1", 64'(bus.count_rs), 64'd1);
    drive_disp(7'h41, 64'd40, 1'b1, 6'd0, 64'd41, 1'b1, 6'd0, 6'd4, 6'd31);
    step();
    idle_inputs();
    check_eq("same_valid", 64'(bus.valid_rs2int), 64'd1);
    check_eq("same_tag",   64'(bus.tag_rs2int), 64'd30);
    check_eq("same_count", 64'(bus.count_rs), 64'd1);
    step();
    check_eq("same_next_tag", 64'(bus.tag_rs2int), 64'd31);
    check_eq("same_next_a",   bus.a_rs2int, 64'd40);
    check_eq("same_next_opc", 64'(bus.opcode_rs2int), 64'h41);
    check_eq("same_next_cnt", 64'(bus.count_rs), 64'd0);
    step();
    check_idle("same_drain");

    // Reset mid-operation discards queued work
    bus.stop_int2rsint = 1'b1;
    drive_disp(7'h50, 64'd5, 1'b1, 6'd0, 64'd6, 1'b1, 6'd0, 6'd5, 6'd40);
    step();
    drive_disp(7'h51, 64'd7, 1'b1, 6'd0, 64'd8, 1'b1, 6'd0, 6'd6, 6'd41);
    step();
    idle_inputs();
    check_eq("mid_count2", 64'(bus.count_rs), 64'd2);
    bus.stop_int2rsint = 1'b0;
    res = 1'b1;
    step();
    check_idle("mid_reset");
    check_eq("mid_reset_tag", 64'(bus.tag_rs2int), 64'd0);
    res = 1'b0;
    step();
    check_idle("mid_after");
    step();
    check_idle("mid_after2");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rs_int_scheduler.md
Name: rs_int_scheduler

Overview:
- Integer reservation station and issue scheduler in front of `integer_unit`.
- Holds up to DEPTH dispatched integer ops and captures missing operands by snooping the result broadcast bus (CDB).
- Each cycle it issues the oldest op with both operands ready to `integer_unit`, and honours that unit's stop signal.
- Sits between dispatch/rename and `integer_unit`; `integer_unit` results go to the ROB and come back as the CDB.

Parameters:
- DEPTH, 4, number of station entries (2..16).
- XLEN, 64, operand/result width.
- TAGW, 6, ROB tag width; rd width is also TAGW.

Ports:
- clk  in  1  clock
- res  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of all entries (mispredict)
- valid_disp2rs  in  1  dispatch request
- opcode_disp2rs  in  7  opcode
- a_val_disp2rs / b_val_disp2rs  in  XLEN  operand values (meaningful when ready)
- a_rdy_disp2rs / b_rdy_disp2rs  in  1  operand already available
- a_tag_disp2rs / b_tag_disp2rs  in  TAGW  producer tag when not ready
- rd_disp2rs  in  TAGW  destination register
- tag_disp2rs  in  TAGW  ROB tag of this op
- full_rs2disp  out  1  station cannot accept dispatch this cycle
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAGW  broadcast tag
- cdb_result  in  XLEN  broadcast value
- valid_rs2int  out  1  issue valid
- opcode_rs2int  out  7
- a_rs2int / b_rs2int  out  XLEN
- rd_rs2int / tag_rs2int  out  TAGW
- stop_int2rsint  in  1  integer unit busy; do not issue
- count_rs  out  $clog2(DEPTH+1)  occupied entries (debug/perf)

Behaviour:
- Reset (res high at posedge):
  - all entries invalid.
  - valid_rs2int=0; opcode/a/b/rd/tag outputs=0.
  - count_rs=0; full_rs2disp=0.
  - reset mid-operation discards everything in flight.
- Storage is a collapsing queue. Entry 0 is the oldest. Valid entries are always contiguous at indices 0..count-1.
- full_rs2disp = (count_rs == DEPTH), combinational from registered count.
  - Dispatch while full is ignored; the dispatcher must hold.
  - A same-cycle issue does not free space for that cycle's dispatch.
- Dispatch (valid_disp2rs & !full & !flush):
  - Written at the clock edge into slot count (or count-1 if an entry is removed the same edge).
  - An operand is captured as ready with cdb_result if the operand is not ready and cdb_valid with cdb_tag equal to its tag in that same cycle (dispatch bypass).
- Wakeup:
  - Each cycle, for every valid entry, each non-ready operand whose tag equals cdb_tag with cdb_valid set captures cdb_result and becomes ready at the edge.
  - Both operands may wake on the same broadcast.
- Select:
  - Uses registered entry state only. The candidate is the lowest-index entry with both operands ready.
  - An entry woken in cycle N is selectable in N+1.
- Issue:
  - If stop_int2rsint==0 and a candidate exists, the outputs are registered with the candidate's fields at the edge, valid_rs2int=1, and the entry is removed. Entries above it shift down one slot.
  - Otherwise valid_rs2int=0 at the edge and no entry is removed.
  - At most one issue per cycle.
- Latency:
  - Dispatch with both operands ready in cycle N: selectable in N+1, valid_rs2int high in N+2.
  - Back-to-back issue, one per cycle, is allowed while stop is low.
- Count:
  - count_next = count + dispatch_accepted − issued.
  - Dispatch and issue in the same cycle leave count unchanged.
- Flush:
  - At the edge all entries are invalidated, count=0, valid_rs2int=0.
  - Flush overrides a same-cycle dispatch and issue.
- No dependency checks between entries beyond CDB tags. A tag match on a ready operand is ignored.

Decomposition:
- Package rs_pkg:
  - OPCODE_W=7.
  - rs_entry_t struct: valid, opcode, a_val, a_rdy, a_tag, b_val, b_rdy, b_tag, rd, tag.
  - Default XLEN/TAGW constants.
- One natural sub-module, rs_entry_wakeup: combinational per-entry CDB compare and capture, instantiated DEPTH+1 times (the entries plus the dispatch bypass).

Test Plan:
- Reset then idle:
  - Stimulus: res high 2 cycles, then idle.
  - Required: valid_rs2int=0, count_rs=0, full_rs2disp=0 throughout.
- Ready dispatch:
  - Stimulus: dispatch op tag=3, rd=5, a=10 ready, b=20 ready in cycle N.
  - Required: cycle N+2 valid_rs2int=1, a=10, b=20, tag=3, rd=5; N+3 valid=0, count=0.
- Wakeup, out of order:
  - Stimulus: dispatch tag=1 with a waiting on tag 7, then tag=2 fully ready; cdb_valid tag 7 result 0x55 two cycles later.
  - Required: tag 2 issues first; tag 1 issues with a=0x55 two cycles after the broadcast.
- Dispatch bypass:
  - Stimulus: dispatch with b waiting on tag 9 while cdb_valid tag 9 result 0xAA in the same cycle.
  - Required: b=0xAA; issues two cycles later.
- Full and stop:
  - Stimulus: stop_int2rsint held high; dispatch DEPTH=4 ready ops.
  - Required: full_rs2disp=1, a 5th dispatch is dropped, count stays 4. After stop is released, four consecutive issues in age order, then count=0.
- Flush:
  - Stimulus: three entries plus an issue pending, then flush for 1 cycle together with a dispatch.
  - Required: next cycle count=0 and valid_rs2int=0; the dispatched op is never issued.
